sm4_cmd_seq: RTL and testbench

Parametrised command sequencer for the SM4 cipher subsystem. It is the next-generation replacement for the flag-driven SM4 top-level controller. A single valid/ready command port carries five operations: direct key load, key-RAM fetch, key generate-and-store, encrypt and decrypt. The block drives the external key RAM, the key generator and the SM4 encrypt/decrypt core, and returns one response per command with an error flag. It adds features the previous controller lacked: backpressure, RAM timeout, a no-key error and an optional key cache.

---
 rtl/sm4_cmd_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_sm4_cmd_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_cmd_seq.sv
// SM4 command sequencer: one valid/ready command at a time driving key RAM, key generator and cipher core.
// Define SM4_KEY_CACHE_EN to let a FETCH of the already-installed slot skip the RAM read.
module sm4_cmd_seq #(
   parameter int ADDR_W      = 7,
   parameter int KEYGEN_LAT  = 4,
   parameter int RAM_TIMEOUT = 15
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [2:0]        i_cmd_op,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [127:0]      i_cmd_key,
   input  logic [127:0]      i_cmd_data,
   output logic              o_ram_ren,
   output logic              o_ram_wen,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [127:0]      o_ram_wdata,
   input  logic [127:0]      i_ram_rdata,
   input  logic              i_ram_rvalid,
   output logic              o_keygen_en,
   input  logic [127:0]      i_keygen_key,
   output logic [127:0]      o_core_init_key,
   output logic              o_core_init_valid,
   output logic [1:0]        o_core_mode,
   output logic [127:0]      o_core_data,
   output logic              o_core_valid,
   input  logic              i_core_ready,
   input  logic [127:0]      i_core_data,
   input  logic              i_core_valid,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [127:0]      o_rsp_data,
   output logic              o_rsp_err
);
   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_FETCH = 3'd1;
   localparam logic [2:0] OP_GEN   = 3'd2;
   localparam logic [2:0] OP_ENC   = 3'd3;
   localparam logic [2:0] OP_DEC   = 3'd4;
   localparam int CNT_MAX = (RAM_TIMEOUT > KEYGEN_LAT) ? RAM_TIMEOUT : KEYGEN_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, LOAD, RAM_RD, KEYGEN, CORE_REQ, CORE_RUN, RSP} state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [ADDR_W-1:0]   slot_reg, slot_next;
   logic                key_loaded_reg, key_loaded_next;
   logic                cmd_ready_reg, cmd_ready_next;
   logic                ram_ren_reg, ram_ren_next;
   logic                ram_wen_reg, ram_wen_next;
   logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
   logic [127:0]        ram_wdata_reg, ram_wdata_next;
   logic                keygen_en_reg, keygen_en_next;
   logic [127:0]        init_key_reg, init_key_next;
   logic                init_valid_reg, init_valid_next;
   logic [1:0]          core_mode_reg, core_mode_next;
   logic [127:0]        core_data_reg, core_data_next;
   logic                core_valid_reg, core_valid_next;
   logic                rsp_valid_reg, rsp_valid_next;
   logic [127:0]        rsp_data_reg, rsp_data_next;
   logic                rsp_err_reg, rsp_err_next;
   logic                cache_hit;

   // Every output register is loaded with the value belonging to the state being entered.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      slot_next       = slot_reg;
      key_loaded_next = key_loaded_reg;
      ram_ren_next    = 1'b0;
      ram_wen_next    = 1'b0;
      ram_addr_next   = ram_addr_reg;
      ram_wdata_next  = ram_wdata_reg;
      init_key_next   = init_key_reg;
      init_valid_next = 1'b0;
      core_mode_next  = core_mode_reg;
      core_data_next  = core_data_reg;
      rsp_data_next   = rsp_data_reg;
      rsp_err_next    = rsp_err_reg;
      case (state_reg)
         IDLE: begin
            if (i_cmd_valid) begin
               slot_next     = i_cmd_addr;
               cnt_next      = '0;
               rsp_data_next = '0;
               rsp_err_next  = 1'b0;
               case (i_cmd_op)
                  OP_LOAD: begin
                     state_next      = LOAD;
                     init_key_next   = i_cmd_key;
                     init_valid_next = 1'b1;
                  end
                  OP_FETCH: begin
                     if (cache_hit) begin
                        state_next = RSP;
                     end else begin
                        state_next    = RAM_RD;
                        ram_ren_next  = 1'b1;
                        ram_addr_next = i_cmd_addr;
                     end
                  end
                  OP_GEN: state_next = KEYGEN;
                  OP_ENC, OP_DEC: begin
                     if (key_loaded_reg) begin
                        state_next     = CORE_REQ;
                        core_mode_next = (i_cmd_op == OP_ENC) ? 2'b01 : 2'b10;
                        core_data_next = i_cmd_data;
                     end else begin
                        state_next   = RSP;
                        rsp_err_next = 1'b1;
                     end
                  end
                  default: begin
                     state_next   = RSP;
                     rsp_err_next = 1'b1;
                  end
               endcase
            end
         end
         RAM_RD: begin
            cnt_next = cnt_reg + 1'b1;
            if (i_ram_rvalid) begin
               state_next      = LOAD;
               init_key_next   = i_ram_rdata;
               init_valid_next = 1'b1;
            end else if (cnt_reg == CNT_W'(RAM_TIMEOUT - 1)) begin
               state_next   = RSP;
               rsp_err_next = 1'b1;
            end
         end
         KEYGEN: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(KEYGEN_LAT - 1)) begin
               state_next      = LOAD;
               init_key_next   = i_keygen_key;
               init_valid_next = 1'b1;
               ram_wen_next    = 1'b1;
               ram_addr_next   = slot_reg;
               ram_wdata_next  = i_keygen_key;
            end
         end
         LOAD: begin
            key_loaded_next = 1'b1;
            state_next      = RSP;
         end
         CORE_REQ: if (i_core_ready) state_next = CORE_RUN;
         CORE_RUN: begin
            if (i_core_valid) begin
               rsp_data_next = i_core_data;
               state_next    = RSP;
            end
         end
         RSP: if (i_rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      cmd_ready_next  = (state_next == IDLE);
      keygen_en_next  = (state_next == KEYGEN);
      core_valid_next = (state_next == CORE_REQ);
      rsp_valid_next  = (state_next == RSP);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         slot_reg       <= '0;
         key_loaded_reg <= 1'b0;
         cmd_ready_reg  <= 1'b1;
         ram_ren_reg    <= 1'b0;
         ram_wen_reg    <= 1'b0;
         ram_addr_reg   <= '0;
         ram_wdata_reg  <= '0;
         keygen_en_reg  <= 1'b0;
         init_key_reg   <= '0;
         init_valid_reg <= 1'b0;
         core_mode_reg  <= '0;
         core_data_reg  <= '0;
         core_valid_reg <= 1'b0;
         rsp_valid_reg  <= 1'b0;
         rsp_data_reg   <= '0;
         rsp_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         slot_reg       <= slot_next;
         key_loaded_reg <= key_loaded_next;
         cmd_ready_reg  <= cmd_ready_next;
         ram_ren_reg    <= ram_ren_next;
         ram_wen_reg    <= ram_wen_next;
         ram_addr_reg   <= ram_addr_next;
         ram_wdata_reg  <= ram_wdata_next;
         keygen_en_reg  <= keygen_en_next;
         init_key_reg   <= init_key_next;
         init_valid_reg <= init_valid_next;
         core_mode_reg  <= core_mode_next;
         core_data_reg  <= core_data_next;
         core_valid_reg <= core_valid_next;
         rsp_valid_reg  <= rsp_valid_next;
         rsp_data_reg   <= rsp_data_next;
         rsp_err_reg    <= rsp_err_next;
      end
   end

`ifdef SM4_KEY_CACHE_EN
   logic              cache_valid_reg;
   logic [ADDR_W-1:0] cache_slot_reg;
   logic              direct_load_reg;

   assign cache_hit = cache_valid_reg && (cache_slot_reg == i_cmd_addr);

   // A direct LOAD installs a key that matches no slot, so it invalidates the cache.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cache_valid_reg <= 1'b0;
         cache_slot_reg  <= '0;
         direct_load_reg <= 1'b0;
      end else begin
         if (state_reg == IDLE && i_cmd_valid)
            direct_load_reg <= (i_cmd_op == OP_LOAD);
         if (state_reg == LOAD) begin
            cache_valid_reg <= !direct_load_reg;
            if (!direct_load_reg)
               cache_slot_reg <= slot_reg;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   assign o_cmd_ready       = cmd_ready_reg;
   assign o_ram_ren         = ram_ren_reg;
   assign o_ram_wen         = ram_wen_reg;
   assign o_ram_addr        = ram_addr_reg;
   assign o_ram_wdata       = ram_wdata_reg;
   assign o_keygen_en       = keygen_en_reg;
   assign o_core_init_key   = init_key_reg;
   assign o_core_init_valid = init_valid_reg;
   assign o_core_mode       = core_mode_reg;
   assign o_core_data       = core_data_reg;
   assign o_core_valid      = core_valid_reg;
   assign o_rsp_valid       = rsp_valid_reg;
   assign o_rsp_data        = rsp_data_reg;
   assign o_rsp_err         = rsp_err_reg;
endmodule

// File: tb/tb_sm4_cmd_seq.sv
// Directed bench for sm4_cmd_seq with small RAM, key generator and cipher-core models.
// Build with SM4_KEY_CACHE_EN defined to also exercise the key cache.
module tb_sm4_cmd_seq;
   localparam int ADDR_W      = 7;
   localparam int KEYGEN_LAT  = 4;
   localparam int RAM_TIMEOUT = 15;
   localparam logic [127:0] KEY_A  = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] PT     = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] CT     = 128'h681EDF34D206965E86B3E94F536E4246;
   localparam logic [127:0] KEY_S5 = 128'h55555555AAAAAAAA0F0F0F0FF0F0F0F0;
   localparam logic [127:0] KEY_G  = 128'hDEADBEEF00112233445566778899AABB;
   localparam logic [127:0] D_BP   = 128'hA5A5A5A5C3C3C3C3123456789ABCDEF0;

   logic              clk, rst_n;
   logic              cmd_valid, cmd_ready;
   logic [2:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr, ram_addr;
   logic [127:0]      cmd_key, cmd_data, ram_wdata, ram_rdata, keygen_key;
   logic              ram_ren, ram_wen, ram_rvalid, keygen_en;
   logic [127:0]      core_init_key, core_data_o, core_data_i, rsp_data;
   logic              core_init_valid, core_valid_o, core_ready, core_valid_i;
   logic [1:0]        core_mode;
   logic              rsp_valid, rsp_ready, rsp_err;

   int n_tests = 0;
   int n_fail  = 0;
   logic [127:0] core_key_model;

   sm4_cmd_seq #(.ADDR_W(ADDR_W), .KEYGEN_LAT(KEYGEN_LAT), .RAM_TIMEOUT(RAM_TIMEOUT)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
      .i_cmd_addr(cmd_addr), .i_cmd_key(cmd_key), .i_cmd_data(cmd_data),
      .o_ram_ren(ram_ren), .o_ram_wen(ram_wen), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata), .i_ram_rvalid(ram_rvalid),
      .o_keygen_en(keygen_en), .i_keygen_key(keygen_key),
      .o_core_init_key(core_init_key), .o_core_init_valid(core_init_valid),
      .o_core_mode(core_mode), .o_core_data(core_data_o), .o_core_valid(core_valid_o),
      .i_core_ready(core_ready), .i_core_data(core_data_i), .i_core_valid(core_valid_i),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model key register, loaded by the init pulse.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) core_key_model <= '0;
      else if (core_init_valid) core_key_model <= core_init_key;

   // Known SM4 vector for KEY_A; any other combination uses a simple xor stand-in.
   function automatic logic [127:0] core_fn(input logic [127:0] key, input logic [1:0] mode,
                                            input logic [127:0] data);
      if (key == KEY_A && mode == 2'b01 && data == PT) return CT;
      if (key == KEY_A && mode == 2'b10 && data == CT) return PT;
      return data ^ key;
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, {ram_ren, ram_wen, keygen_en, core_init_valid, core_valid_o,
                            rsp_valid, rsp_err, core_mode, ram_addr}, '0);
      check({tag, "_dat"}, core_init_key | ram_wdata | core_data_o | rsp_data, '0);
   endtask

   // Presents a command in the current cycle; returns at the negedge of cycle T+1.
   task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                       input logic [127:0] key, input logic [127:0] data);
      check("cmd_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_key = key; cmd_data = data;
      @(negedge clk);
      cmd_valid = 1'b0;
      $display("[TB] cmd op=%0d addr=%h key=%h data=%h", op, addr, key, data);
   endtask

   task automatic do_load(input logic [127:0] key);
      send(3'd0, '0, key, '0);
      check("load_init_v", core_init_valid, 1'b1);
      check("load_init_k", core_init_key, key);
      check("load_rsp_early", rsp_valid, 1'b0);
      @(negedge clk);
      check("load_init_pulse", core_init_valid, 1'b0);
      check("load_rsp", {rsp_valid, rsp_err}, 2'b10);
      check("load_rsp_data", rsp_data, '0);
      @(negedge clk);
   endtask

   task automatic do_fetch3(input logic [ADDR_W-1:0] slot, input logic [127:0] rdata);
      send(3'd1, slot, '0, '0);
      check("fetch_ren", ram_ren, 1'b1);
      check("fetch_addr", ram_addr, slot);
      @(negedge clk);
      check("fetch_ren_pulse", ram_ren, 1'b0);
      @(negedge clk);
      ram_rvalid = 1'b1; ram_rdata = rdata;
      check("fetch_init_early", core_init_valid, 1'b0);
      @(negedge clk);
      ram_rvalid = 1'b0; ram_rdata = '0;
      check("fetch_init_v", core_init_valid, 1'b1);
      check("fetch_init_k", core_init_key, rdata);
      check("fetch_rsp_early", rsp_valid, 1'b0);
      @(negedge clk);
      check("fetch_rsp", {rsp_valid, rsp_err}, 2'b10);
      @(negedge clk);
   endtask

   task automatic do_core(input logic [2:0] op, input logic [127:0] data, input logic [127:0] exp);
      send(op, '0, '0, data);
      check("core_valid", core_valid_o, 1'b1);
      check("core_mode", core_mode, (op == 3'd3) ? 2'b01 : 2'b10);
      check("core_data", core_data_o, data);
      core_ready = 1'b1;
      @(negedge clk);
      core_ready = 1'b0;
      check("core_valid_drop", core_valid_o, 1'b0);
      core_valid_i = 1'b1;
      core_data_i  = core_fn(core_key_model, core_mode, core_data_o);
      @(negedge clk);
      core_valid_i = 1'b0;
      check("core_rsp", {rsp_valid, rsp_err}, 2'b10);
      check("core_rsp_data", rsp_data, exp);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_key = '0; cmd_data = '0;
      ram_rdata = '0; ram_rvalid = 1'b0; keygen_key = KEY_G;
      core_ready = 1'b0; core_data_i = '0; core_valid_i = 1'b0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b1);

      // ENC with no key loaded errors immediately.
      send(3'd3, '0, '0, PT);
      check("nokey_rsp", {rsp_valid, rsp_err}, 2'b11);
      check("nokey_core_valid", core_valid_o, 1'b0);
      @(negedge clk);
      check("nokey_idle", {cmd_ready, rsp_valid}, 2'b10);

      // Illegal opcode.
      send(3'd6, '0, '0, '0);
      check("illegal_rsp", {rsp_valid, rsp_err}, 2'b11);
      @(negedge clk);

      do_load(KEY_A);
      do_core(3'd3, PT, CT);
      do_core(3'd4, CT, PT);

      do_fetch3(7'd5, KEY_S5);

      // Silent RAM: timeout error, previously loaded key still usable.
      send(3'd1, 7'd9, '0, '0);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("timeout_lat", lat, RAM_TIMEOUT + 1);
      check("timeout_err", {rsp_valid, rsp_err}, 2'b11);
      @(negedge clk);
      do_core(3'd3, PT, PT ^ KEY_S5);

      // Key generate into slot 0x7F.
      send(3'd2, 7'h7F, '0, '0);
      for (int k = 1; k <= KEYGEN_LAT; k++) begin
         check($sformatf("gen_en_%0d", k), {keygen_en, ram_wen, core_init_valid}, 3'b100);
         @(negedge clk);
      end
      check("gen_wen_init", {keygen_en, ram_wen, core_init_valid, rsp_valid}, 4'b0110);
      check("gen_addr", ram_addr, 7'h7F);
      check("gen_wdata", ram_wdata, KEY_G);
      check("gen_init_k", core_init_key, KEY_G);
      @(negedge clk);
      check("gen_rsp", {rsp_valid, rsp_err, ram_wen}, 3'b100);
      @(negedge clk);
      do_core(3'd3, PT, PT ^ KEY_G);

      // Backpressure on both core input and response.
      send(3'd3, '0, '0, D_BP);
      for (int k = 0; k < 5; k++) begin
         check("bp_core_hold", {core_valid_o, core_mode, cmd_ready}, 4'b1010);
         check("bp_core_data", core_data_o, D_BP);
         @(negedge clk);
      end
      core_ready = 1'b1;
      check("bp_core_valid", core_valid_o, 1'b1);
      @(negedge clk);
      core_ready = 1'b0;
      check("bp_core_done", core_valid_o, 1'b0);
      core_valid_i = 1'b1;
      core_data_i  = core_fn(core_key_model, core_mode, core_data_o);
      rsp_ready = 1'b0;
      @(negedge clk);
      core_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("bp_rsp_hold", {rsp_valid, rsp_err, cmd_ready}, 3'b100);
         check("bp_rsp_data", rsp_data, D_BP ^ KEY_G);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      check("bp_rsp_valid", rsp_valid, 1'b1);
      @(negedge clk);
      check("bp_idle", {cmd_ready, rsp_valid}, 2'b10);

      // Reset while waiting for the core result.
      send(3'd3, '0, '0, PT);
      core_ready = 1'b1;
      @(negedge clk);
      core_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check_quiet("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready", {cmd_ready, rsp_valid}, 2'b10);
      send(3'd3, '0, '0, PT);
      check("midrst_nokey", {rsp_valid, rsp_err, core_valid_o}, 3'b110);
      @(negedge clk);

`ifdef SM4_KEY_CACHE_EN
      do_fetch3(7'd5, KEY_S5);
      send(3'd1, 7'd5, '0, '0);
      check("cache_hit", {ram_ren, core_init_valid, rsp_valid, rsp_err}, 4'b0010);
      @(negedge clk);
      do_load(KEY_A);
      do_fetch3(7'd5, KEY_S5);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
